bram_burst_reader: RTL and testbench

- Read-side client for the team's one-cycle dual-port block RAM.
- Accepts burst requests (base address, length) and drives the RAM read port (RD_ADDR/RE).
- Collects DO/DO_VALID and presents the words as a valid/ready stream with a last-word marker.
- Credit-based buffering absorbs RAM latency, so stream backpressure never loses a word; the RAM port itself has no stall.

---
 rtl/bram_reader_pkg.sv | 19 +
 rtl/bram_reader_fifo.sv | 71 +++++++
 rtl/bram_burst_reader.sv | 169 ++++++++++++++++
 tb/tb_bram_burst_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the block-RAM burst reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest buffer that still sustains one word per cycle across the
  // two-cycle RE -> DO_VALID -> push loop.
  localparam int MIN_FIFO_DEPTH = 3;

  // A burst may cover the whole RAM, so the length needs one extra bit.
  function automatic int len_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bram_reader_fifo.sv
// Show-ahead FIFO holding {last, data} entries for the burst reader.
// The head entry is visible whenever the FIFO is non-empty; the output
// reads as zero when empty so the stream bus is quiet between bursts.
module bram_reader_fifo #(
  parameter int WIDTH       = 33,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   valid,
  output logic                   full,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   empty;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == COUNT_WIDTH'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign valid   = !empty;
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read client for the one-cycle dual-port block RAM.
// Issues RAM reads under a credit limit (buffer occupancy plus the read in
// flight never exceeds FIFO_DEPTH) and streams the words out valid/ready.
// Optional protocol checking is enabled with BRAM_BURST_READER_CHECK_EN.
module bram_burst_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH:0]   req_len,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  dout_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err
);

  localparam int LEN_WIDTH   = len_width(ADDR_WIDTH);
  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_depth_check
      $error("bram_burst_reader: FIFO_DEPTH must be at least %0d", MIN_FIFO_DEPTH);
    end
  endgenerate

  state_t                 state;
  state_t                 state_next;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [LEN_WIDTH-1:0]   remaining_q;
  logic [LEN_WIDTH-1:0]   remaining_next;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic                   issue;
  logic                   issue_last;
  logic [COUNT_WIDTH-1:0] occ;
  logic [COUNT_WIDTH:0]   credit_used;
  logic                   fifo_valid;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic                   drain_done;
  logic [DATA_WIDTH:0]    head;

  // Everything feeding RE comes from registers, so stream backpressure
  // never reaches the RAM port combinationally.
  assign credit_used = {1'b0, occ} + {{COUNT_WIDTH{1'b0}}, inflight_q};
  assign pop         = fifo_valid && out_ready;

  // Leave DRAIN so that REQ_READY is back the cycle after the final pop.
  assign drain_done  = !inflight_q &&
                       ((occ == '0) || ((occ == COUNT_WIDTH'(1)) && pop));

  // Next-state, address/length counters and read issue.
  always_comb begin
    state_next     = state;
    addr_next      = addr_q;
    remaining_next = remaining_q;
    issue          = 1'b0;
    issue_last     = 1'b0;
    req_ready      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_next      = req_addr;
          remaining_next = req_len;
          if (req_len != '0) begin
            state_next = READ;
          end
        end
      end
      READ: begin
        if (credit_used < (COUNT_WIDTH + 1)'(FIFO_DEPTH)) begin
          issue          = 1'b1;
          addr_next      = addr_q + ADDR_WIDTH'(1);
          remaining_next = remaining_q - LEN_WIDTH'(1);
          if (remaining_q == LEN_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters and the one-deep record of the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state           <= state_next;
      addr_q          <= addr_next;
      remaining_q     <= remaining_next;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
    end
  end

`ifdef BRAM_BURST_READER_CHECK_EN
  logic spurious;
  logic overflow;
  logic err_q;

  assign spurious = dout_valid && !inflight_q;
  assign overflow = dout_valid && inflight_q && fifo_full;
  assign push     = dout_valid && !spurious && !overflow;
  assign err      = err_q;

  // Sticky error flag: unexpected RAM data or a push into a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (spurious || overflow) begin
      err_q <= 1'b1;
    end
  end
`else
  assign push = dout_valid;
  assign err  = 1'b0;
`endif

  bram_reader_fifo #(
    .WIDTH      (DATA_WIDTH + 1),
    .DEPTH      (FIFO_DEPTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_data({inflight_last_q, dout}),
    .pop    (pop),
    .rd_data(head),
    .valid  (fifo_valid),
    .full   (fifo_full),
    .count  (occ)
  );

  assign re        = issue;
  assign rd_addr   = addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = head[DATA_WIDTH-1:0];
  assign out_last  = head[DATA_WIDTH];
  assign busy      = (state != IDLE) || fifo_valid;

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench for bram_burst_reader with a one-cycle RAM model.
// Expected words come from a queue built from the burst address/length;
// protocol checks (address sequence, credit bound, hold-while-stalled,
// latency, REQ_READY return) are derived from word counts, not RTL state.
// Define BRAM_BURST_READER_CHECK_EN to also exercise the error flag.
module tb_bram_burst_reader;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [AW-1:0] rd_addr;
  logic          re;
  logic [DW-1:0] dout = '0;
  logic          dout_valid = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          err;
  logic          inject = 1'b0;

  logic [DW-1:0] mem [WORDS];
  logic [DW:0]   exp_q [$];

  int n_vectors     = 0;
  int n_miscompares = 0;

  bram_burst_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rd_addr   (rd_addr),
    .re        (re),
    .dout      (dout),
    .dout_valid(dout_valid),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // One-cycle RAM: data and valid appear the cycle after RE.
  always @(posedge clk) begin
    dout_valid <= re | inject;
    if (re) dout <= mem[rd_addr];
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vectors++;
    assert (obs === expv)
    else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_mem(input bit identity);
    for (int i = 0; i < WORDS; i++) mem[i] = identity ? DW'(i) : $urandom;
  endtask

  // Run one burst; abort_after >= 0 stops once that many words were taken.
  task automatic apply_stimulus(input logic [AW-1:0] a, input int len, input int ready_pct,
                                input bit check_lat, input int abort_after);
    int            issued;
    int            popped;
    int            cycle;
    int            first_pop;
    int            last_pop;
    int            wait_cnt;
    bit            hold;
    bit            aborted;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] ea;
    logic [DW:0]   e;

    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      ea = a + AW'(i);
      exp_q.push_back({(i == len - 1), mem[ea]});
    end

    wait_cnt = 0;
    @(negedge clk);
    while (!req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check_output("req_ready_before_burst", req_ready, 1'b1);

    req_valid = 1'b1;
    req_addr  = a;
    req_len   = LW'(len);
    @(posedge clk);
    #1 req_valid = 1'b0;

    issued = 0; popped = 0; cycle = 0; first_pop = -1; last_pop = -1;
    hold = 1'b0; aborted = 1'b0; prev_data = '0; prev_last = 1'b0;

    while (popped < len && cycle < 20 * len + 40) begin
      @(negedge clk);
      cycle++;
      out_ready = ($urandom_range(99) < ready_pct);
      if (re) begin
        ea = a + AW'(issued);
        check_output("rd_addr", rd_addr, ea);
        check_output("credit_bound", (issued - popped) < DEPTH, 1'b1);
        check_output("re_within_len", issued < len, 1'b1);
        issued++;
      end
      if (hold) begin
        check_output("hold_valid", out_valid, 1'b1);
        check_output("hold_data", out_data, prev_data);
        check_output("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check_output("out_data", out_data, e[DW-1:0]);
        check_output("out_last", out_last, e[DW]);
        if (first_pop < 0) first_pop = cycle;
        last_pop = cycle;
        popped++;
      end
      hold      = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (abort_after >= 0 && popped == abort_after) begin
        aborted = 1'b1;
        break;
      end
    end

    if (!aborted) begin
      check_output("words_received", popped, len);
      if (check_lat) begin
        check_output("first_word_latency", first_pop, 3);
        check_output("back_to_back", last_pop - first_pop, len - 1);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_output("req_ready_after_last", req_ready, 1'b1);
      check_output("no_extra_word", out_valid, 1'b0);
      check_output("busy_after_burst", busy, 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b1;
    fill_mem(1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_req_ready", req_ready, 1'b1);
    check_output("rst_re", re, 1'b0);
    check_output("rst_rd_addr", rd_addr, '0);
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out_last", out_last, 1'b0);
    check_output("rst_out_data", out_data, '0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_err", err, 1'b0);

    $display("[TB] identity burst and address wrap");
    apply_stimulus(9'h010, 4, 100, 1'b1, -1);
    apply_stimulus(9'h1FE, 4, 100, 1'b1, -1);

    $display("[TB] random data with backpressure");
    fill_mem(1'b0);
    apply_stimulus(AW'($urandom), 16, 50, 1'b0, -1);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(AW'($urandom), $urandom_range(20, 1), $urandom_range(100, 30), 1'b0, -1);
    end
    apply_stimulus(AW'($urandom), WORDS, 80, 1'b0, -1);

    $display("[TB] zero-length request");
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 9'h055;
    req_len   = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("len0_re", re, 1'b0);
      check_output("len0_out_valid", out_valid, 1'b0);
      check_output("len0_busy", busy, 1'b0);
      check_output("len0_req_ready", req_ready, 1'b1);
    end

    $display("[TB] reset mid-burst");
    apply_stimulus(AW'($urandom), 10, 100, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", out_valid, 1'b0);
    check_output("midrst_re", re, 1'b0);
    check_output("midrst_busy", busy, 1'b0);
    check_output("midrst_out_data", out_data, '0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(AW'($urandom), 2, 100, 1'b1, -1);

`ifdef BRAM_BURST_READER_CHECK_EN
    $display("[TB] spurious DO_VALID in IDLE");
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    check_output("err_set", err, 1'b1);
    check_output("err_no_output", out_valid, 1'b0);
    repeat (3) @(negedge clk);
    check_output("err_sticky", err, 1'b1);
    check_output("err_still_no_output", out_valid, 1'b0);
`else
    check_output("err_tied_low", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
